// File: rtl/arith_pkg.sv
// Shared types for the arithmetic unit: opcode encodings and control FSM states.
package arith_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0110,
        OP_SUB = 4'b0111,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/arith_op_unit_if.sv
// Request/response bundle between the opcode decoder (master) and the arithmetic unit (slave).
interface arith_op_unit_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     op_code;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] y;
    logic           v;
    logic           dz;
    logic           err;

    modport master (
        output in_valid, op_code, a, b, out_ready,
        input  in_ready, out_valid, y, v, dz, err
    );

    modport slave (
        input  in_valid, op_code, a, b, out_ready,
        output in_ready, out_valid, y, v, dz, err
    );
endinterface

// File: rtl/arith_iter_muldiv.sv
// Bit-serial engine shared by unsigned shift-add multiply and restoring divide.
// Runs W iterations after start; done is high during the final iteration and result shows its outcome.
module arith_iter_muldiv #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           div_mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] result
);
    localparam int CW = $clog2(W);

    // hi holds the partial product / remainder, lo the multiplier / quotient being shifted
    logic [W-1:0]  hi_reg;
    logic [W-1:0]  lo_reg;
    logic [W-1:0]  opb_reg;
    logic          div_reg;
    logic          busy_reg;
    logic [CW-1:0] cnt_reg;

    logic [W:0]    mul_sum;
    logic [W-1:0]  mul_lo_next;
    logic [W:0]    div_sh;
    logic          div_ge;
    logic [W-1:0]  div_hi_next;
    logic [W-1:0]  div_lo_next;
    logic [W-1:0]  hi_next;
    logic [W-1:0]  lo_next;

    assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : {(W+1){1'b0}});
    assign div_sh  = {hi_reg, lo_reg[W-1]};
    assign div_ge  = (div_sh >= {1'b0, opb_reg});
    // remainder stays below the divisor, so the difference always fits in W bits
    assign div_hi_next = div_ge ? (div_sh[W-1:0] - opb_reg) : div_sh[W-1:0];

    assign mul_lo_next[W-1] = mul_sum[0];
    assign div_lo_next[0]   = div_ge;

    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_shift
            assign mul_lo_next[gi]     = lo_reg[gi+1];
            assign div_lo_next[gi+1]   = lo_reg[gi];
        end
    endgenerate

    assign hi_next = div_reg ? div_hi_next : mul_sum[W:1];
    assign lo_next = div_reg ? div_lo_next : mul_lo_next;
    assign done    = busy_reg && (cnt_reg == '0);
    assign result  = {hi_next, lo_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            opb_reg  <= '0;
            div_reg  <= 1'b0;
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (start) begin
            hi_reg   <= '0;
            lo_reg   <= a;
            opb_reg  <= b;
            div_reg  <= div_mode;
            busy_reg <= 1'b1;
            cnt_reg  <= CW'(W - 1);
        end else if (busy_reg) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arith_op_unit.sv
// W-bit add/sub/mul/div unit behind a valid/ready handshake, one operation in flight.
// Define ARITH_SAT_EN to saturate add/sub results on signed overflow instead of wrapping.
module arith_op_unit
    import arith_pkg::*;
#(
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst,
    arith_op_unit_if.slave bus
);
    state_e         state_reg;
    logic           in_ready_reg;
    logic           out_valid_reg;
    logic [2*W-1:0] y_reg;
    logic           v_reg;
    logic           dz_reg;
    logic           err_reg;

    logic           is_sub;
    logic [W-1:0]   s_raw;
    logic [W-1:0]   s_fin;
    logic           ovf;
    logic           md_start;
    logic           md_done;
    logic [2*W-1:0] md_result;

    always_comb begin
        is_sub = (bus.op_code == OP_SUB);
        s_raw  = is_sub ? (bus.a - bus.b) : (bus.a + bus.b);
        if (is_sub) begin
            ovf = (bus.a[W-1] != bus.b[W-1]) && (s_raw[W-1] != bus.a[W-1]);
        end else begin
            ovf = (bus.a[W-1] == bus.b[W-1]) && (s_raw[W-1] != bus.a[W-1]);
        end
        s_fin = s_raw;
`ifdef ARITH_SAT_EN
        // overflow direction follows the sign of a for both add and sub
        if (ovf) begin
            s_fin = bus.a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // divide by zero short-circuits straight to DONE without touching the iterator
    assign md_start = (state_reg == IDLE) && bus.in_valid &&
                      ((bus.op_code == OP_MUL) || ((bus.op_code == OP_DIV) && (bus.b != '0)));

    arith_iter_muldiv #(.W(W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (md_start),
        .div_mode (bus.op_code == OP_DIV),
        .a        (bus.a),
        .b        (bus.b),
        .done     (md_done),
        .result   (md_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            v_reg         <= 1'b0;
            dz_reg        <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_reg <= 1'b0;
                        v_reg        <= 1'b0;
                        dz_reg       <= 1'b0;
                        err_reg      <= 1'b0;
                        case (bus.op_code)
                            OP_ADD, OP_SUB: begin
                                y_reg         <= {{W{s_fin[W-1]}}, s_fin};
                                v_reg         <= ovf;
                                out_valid_reg <= 1'b1;
                                state_reg     <= DONE;
                            end
                            OP_MUL: state_reg <= MUL;
                            OP_DIV: begin
                                if (bus.b == '0) begin
                                    y_reg         <= {bus.a, {W{1'b1}}};
                                    dz_reg        <= 1'b1;
                                    out_valid_reg <= 1'b1;
                                    state_reg     <= DONE;
                                end else begin
                                    state_reg <= DIV;
                                end
                            end
                            default: begin
                                y_reg         <= '0;
                                err_reg       <= 1'b1;
                                out_valid_reg <= 1'b1;
                                state_reg     <= DONE;
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        y_reg         <= md_result;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.y         = y_reg;
    assign bus.v         = v_reg;
    assign bus.dz        = dz_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_arith_op_unit.sv
// Self-checking bench for arith_op_unit (W=4): directed cases, exhaustive sweep and random ops vs. an integer model.
module tb_arith_op_unit;
    import arith_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arith_op_unit_if #(.W(W)) bus ();

    arith_op_unit #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: signed/unsigned integer arithmetic straight from the operation definitions.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] y, output logic v, output logic dz,
                         output logic err, output int lat);
        int sa, sb, r, full;
        full = 1 << W;
        sa = int'(a);
        sb = int'(b);
        if (sa >= full / 2) sa -= full;
        if (sb >= full / 2) sb -= full;
        r = 0; v = 1'b0; dz = 1'b0; err = 1'b0; lat = 1;
        case (op)
            4'b0110, 4'b0111: begin
                r = (op == 4'b0110) ? sa + sb : sa - sb;
                v = (r > full / 2 - 1) || (r < -full / 2);
`ifdef ARITH_SAT_EN
                if (r > full / 2 - 1) r = full / 2 - 1;
                else if (r < -full / 2) r = -full / 2;
`else
                if (r > full / 2 - 1) r -= full;
                else if (r < -full / 2) r += full;
`endif
            end
            4'b1000: begin
                r = int'(a) * int'(b);
                lat = W + 1;
            end
            4'b1001: begin
                if (b == '0) begin
                    r = int'(a) * full + (full - 1);
                    dz = 1'b1;
                end else begin
                    r = (int'(a) % int'(b)) * full + int'(a) / int'(b);
                    lat = W + 1;
                end
            end
            default: err = 1'b1;
        endcase
        y = r[2*W-1:0];
    endtask

    // Drives one operation, holds out_ready low for 'hold' cycles, then retires it.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, output logic [2*W-1:0] y_o, output logic v_o,
                          output logic dz_o, output logic err_o, output int lat,
                          output int busy_bad, output int hold_bad, output int rel_bad);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.op_code   = op;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op_code  = 4'($urandom);
        lat = 1;
        busy_bad = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        if (bus.in_ready !== 1'b0) busy_bad++;
        y_o = bus.y; v_o = bus.v; dz_o = bus.dz; err_o = bus.err;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.y !== y_o || bus.v !== v_o ||
                bus.dz !== dz_o || bus.err !== err_o || bus.in_ready !== 1'b0)
                hold_bad++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        rel_bad = (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) ? 1 : 0;
        $display("op=%b a=%h b=%h hold=%0d -> y=%h v=%b dz=%b err=%b lat=%0d",
                 op, a, b, hold, y_o, v_o, dz_o, err_o, lat);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_code = 4'h0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.y, bus.v, bus.dz, bus.err} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b y=%h v=%b dz=%b err=%b required rdy=1 vld=0 y=00 flags=0",
                     bus.in_ready, bus.out_valid, bus.y, bus.v, bus.dz, bus.err);
        end
    endtask

    task automatic test_add_sub();
        logic [2*W-1:0] y; logic v, dz, err; int lat, bb, hb, rb;
        logic [2*W-1:0] ey;
        run_op(4'b0110, 4'b0111, 4'b0001, 0, y, v, dz, err, lat, bb, hb, rb);
`ifdef ARITH_SAT_EN
        ey = 8'h07;
`else
        ey = 8'hF8;
`endif
        checks++;
        if ({y, v, lat} !== {ey, 1'b1, 32'sd1}) begin
            errors++;
            $display("FAIL add_ovf got y=%h v=%b lat=%0d required y=%h v=1 lat=1", y, v, lat, ey);
        end
        run_op(4'b0111, 4'b1000, 4'b0001, 0, y, v, dz, err, lat, bb, hb, rb);
`ifdef ARITH_SAT_EN
        ey = 8'hF8;
`else
        ey = 8'h07;
`endif
        checks++;
        if ({y, v} !== {ey, 1'b1}) begin
            errors++;
            $display("FAIL sub_ovf got y=%h v=%b required y=%h v=1", y, v, ey);
        end
        run_op(4'b0111, 4'b0101, 4'b0011, 0, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if ({y, v, dz, err} !== {8'h02, 3'b000}) begin
            errors++;
            $display("FAIL sub_plain got y=%h v=%b required y=02 v=0", y, v);
        end
    endtask

    task automatic test_mul();
        logic [2*W-1:0] y; logic v, dz, err; int lat, bb, hb, rb;
        run_op(4'b1000, 4'b1111, 4'b1111, 0, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if ({y, v, dz, err} !== {8'hE1, 3'b000}) begin
            errors++;
            $display("FAIL mul_ff got y=%h v=%b required y=e1 v=0", y, v);
        end
        checks++;
        if (lat !== W + 1) begin
            errors++;
            $display("FAIL mul_latency got %0d required %0d", lat, W + 1);
        end
        checks++;
        if (bb !== 0) begin
            errors++;
            $display("FAIL mul_in_ready_low got %0d high samples required 0", bb);
        end
    endtask

    task automatic test_div();
        logic [2*W-1:0] y; logic v, dz, err; int lat, bb, hb, rb;
        run_op(4'b1001, 4'b1101, 4'b0011, 0, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if ({y, dz, lat} !== {8'h14, 1'b0, 32'sd5}) begin
            errors++;
            $display("FAIL div_13_3 got y=%h dz=%b lat=%0d required y=14 dz=0 lat=5", y, dz, lat);
        end
        run_op(4'b1001, 4'b1001, 4'b0000, 0, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if ({y, dz, lat} !== {8'h9F, 1'b1, 32'sd1}) begin
            errors++;
            $display("FAIL div_by_zero got y=%h dz=%b lat=%0d required y=9f dz=1 lat=1", y, dz, lat);
        end
        run_op(4'b0110, 4'b0001, 4'b0001, 0, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if ({y, v, dz, err} !== {8'h02, 3'b000}) begin
            errors++;
            $display("FAIL flags_cleared got y=%h v=%b dz=%b err=%b required y=02 flags=0", y, v, dz, err);
        end
    endtask

    task automatic test_illegal();
        logic [2*W-1:0] y; logic v, dz, err; int lat, bb, hb, rb;
        run_op(4'b0000, 4'b1010, 4'b0101, 0, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if ({y, v, dz, err, lat} !== {8'h00, 3'b001, 32'sd1}) begin
            errors++;
            $display("FAIL illegal_op got y=%h v=%b dz=%b err=%b lat=%0d required y=00 err=1 lat=1",
                     y, v, dz, err, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] y; logic v, dz, err; int lat, bb, hb, rb;
        run_op(4'b1001, 4'b1101, 4'b0011, 3, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if (hb !== 0) begin
            errors++;
            $display("FAIL backpressure_hold got %0d unstable samples required 0", hb);
        end
        checks++;
        if (rb !== 0) begin
            errors++;
            $display("FAIL backpressure_release got %0d required 0 (out_valid low, in_ready high)", rb);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] y1;
        logic bubble_vld;
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.op_code = 4'b0110; bus.a = 4'h1; bus.b = 4'h1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 4'h2; bus.b = 4'h3; bus.out_ready = 1'b1;
        y1 = bus.y;
        @(posedge clk); #1;
        bubble_vld = bus.out_valid;
        checks++;
        if ({bubble_vld, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bubble_after_done got vld=%b rdy=%b required vld=0 rdy=1", bubble_vld, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({y1, bus.out_valid, bus.y} !== {8'h02, 1'b1, 8'h05}) begin
            errors++;
            $display("FAIL back_to_back got y1=%h vld=%b y2=%h required y1=02 vld=1 y2=05",
                     y1, bus.out_valid, bus.y);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        $display("b2b add 1+1 then 2+3 -> y1=%h bubble_vld=%b", y1, bubble_vld);
    endtask

    task automatic test_reset_abort();
        logic [2*W-1:0] y; logic v, dz, err; int lat, bb, hb, rb;
        int stray;
        bus.op_code = 4'b1000; bus.a = 4'hF; bus.b = 4'hF; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.y, bus.in_ready} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_abort got vld=%b y=%h rdy=%b required vld=0 y=00 rdy=1",
                     bus.out_valid, bus.y, bus.in_ready);
        end
        stray = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL reset_abort_dropped got %0d valid cycles required 0", stray);
        end
        run_op(4'b0110, 4'b0011, 4'b0010, 0, y, v, dz, err, lat, bb, hb, rb);
        checks++;
        if ({y, v, lat} !== {8'h05, 1'b0, 32'sd1}) begin
            errors++;
            $display("FAIL add_after_abort got y=%h v=%b lat=%0d required y=05 v=0 lat=1", y, v, lat);
        end
    endtask

    task automatic test_sweep();
        logic [2*W-1:0] y, ey; logic v, dz, err, ev, edz, eerr; int lat, elat, bb, hb, rb;
        for (int op = 6; op <= 9; op++) begin
            for (int ai = 0; ai < (1 << W); ai++) begin
                for (int bi = 0; bi < (1 << W); bi++) begin
                    model(4'(op), W'(ai), W'(bi), ey, ev, edz, eerr, elat);
                    run_op(4'(op), W'(ai), W'(bi), 0, y, v, dz, err, lat, bb, hb, rb);
                    checks++;
                    if ({y, v, dz, err, lat, rb} !== {ey, ev, edz, eerr, elat, 32'sd0}) begin
                        errors++;
                        $display("FAIL sweep op=%0d a=%h b=%h got y=%h v=%b dz=%b err=%b lat=%0d rel=%0d required y=%h v=%b dz=%b err=%b lat=%0d",
                                 op, ai, bi, y, v, dz, err, lat, rb, ey, ev, edz, eerr, elat);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] y, ey; logic v, dz, err, ev, edz, eerr; int lat, elat, bb, hb, rb;
        logic [3:0] op; logic [W-1:0] a, b; int hold;
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) < 8) ? 4'(6 + $urandom_range(0, 3)) : 4'($urandom);
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            hold = $urandom_range(0, 3);
            model(op, a, b, ey, ev, edz, eerr, elat);
            run_op(op, a, b, hold, y, v, dz, err, lat, bb, hb, rb);
            checks++;
            if ({y, v, dz, err, lat, bb, hb, rb} !== {ey, ev, edz, eerr, elat, 32'sd0, 32'sd0, 32'sd0}) begin
                errors++;
                $display("FAIL random op=%b a=%h b=%h got y=%h v=%b dz=%b err=%b lat=%0d busy=%0d hold=%0d rel=%0d required y=%h v=%b dz=%b err=%b lat=%0d",
                         op, a, b, y, v, dz, err, lat, bb, hb, rb, ey, ev, edz, eerr, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
